// File: rtl/mult_err_monitor_pkg.sv
// ----------------------------------------------------------------------------
// mult_err_monitor_pkg
//   Shared definitions for the multiplier error monitor: default product
//   width, default window length and the FSM state encoding.
//   No ports (package).
// ----------------------------------------------------------------------------
package mult_err_monitor_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_WINDOW = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mult_err_monitor_err_dist_stage.sv
// ----------------------------------------------------------------------------
// err_dist_stage
//   Registered first pipeline stage: error distance |a - b| and its
//   non-zero flag for one accepted sample.
//   Ports:
//     clk, rst     clock, async active-high reset
//     v_in         sample valid (accepted this cycle)
//     a, b         approximate / exact product
//     v_out        registered valid
//     ed           registered |a - b|
//     nz           registered (ed != 0)
// ----------------------------------------------------------------------------
module err_dist_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             v_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             v_out,
   output logic [WIDTH-1:0] ed,
   output logic             nz
);

   logic signed [WIDTH:0] diff;
   logic [WIDTH-1:0]      ed_d;
   logic                  v_q, nz_q;
   logic [WIDTH-1:0]      ed_q;

   // One extra bit keeps the sign; the magnitude of a WIDTH+1 signed
   // difference of two unsigned WIDTH values always fits in WIDTH bits.
   assign diff = $signed({1'b0, a}) - $signed({1'b0, b});
   assign ed_d = diff[WIDTH] ? WIDTH'(-diff) : WIDTH'(diff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q  <= 1'b0;
         ed_q <= '0;
         nz_q <= 1'b0;
      end else begin
         v_q <= v_in;
         if (v_in) begin
            ed_q <= ed_d;
            nz_q <= |ed_d;
         end
      end
   end

   assign v_out = v_q;
   assign ed    = ed_q;
   assign nz    = nz_q;

endmodule

// File: rtl/mult_err_monitor.sv
// ----------------------------------------------------------------------------
// mult_err_monitor
//   Windowed error-metric collector for approximate vs. exact multiplier
//   products. Over WINDOW accepted samples it accumulates the sum of error
//   distances, the maximum error distance and the count of mismatches.
//   Results hold until the next window is started.
//   Ports:
//     clk, rst             clock, async active-high reset
//     start                open a window (only in IDLE/DONE)
//     in_valid / in_ready  sample handshake
//     p_approx, p_exact    products for the same operands
//     busy                 window in progress (RUN or DRAIN)
//     done                 one-cycle pulse when results are final
//     ed_sum, ed_max       sum / max of error distance
//     err_count            samples with non-zero error distance
//     smp_count            samples accepted in this window
// ----------------------------------------------------------------------------
module mult_err_monitor
   import mult_err_monitor_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WINDOW = DEF_WINDOW,
   parameter int CNT_W  = $clog2(WINDOW + 1),
   parameter int SUM_W  = WIDTH + $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p_approx,
   input  logic [WIDTH-1:0] p_exact,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] ed_sum,
   output logic [WIDTH-1:0] ed_max,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] smp_count
);

   localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);

   state_t state_q, state_d;

   logic             accept, clear;
   logic             s1_v, s1_nz;
   logic [WIDTH-1:0] s1_ed;
   // [0] = sample entering S1 this cycle, [1] = S1 holding a sample
   logic [1:0]       vld_pipe;

   logic [CNT_W-1:0] smp_count_q, smp_count_d, smp_inc;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [SUM_W-1:0] ed_sum_q, ed_sum_d;
   logic [WIDTH-1:0] ed_max_q, ed_max_d;

   assign accept   = in_valid & in_ready;
   assign clear    = start & ((state_q == IDLE) | (state_q == DONE));
   assign smp_inc  = smp_count_q + CNT_W'(1);
   assign vld_pipe = {s1_v, accept};

   // ---------------- S1: error distance ----------------
   err_dist_stage #(.WIDTH(WIDTH)) u_s1 (
      .clk   (clk),
      .rst   (rst),
      .v_in  (accept),
      .a     (p_approx),
      .b     (p_exact),
      .v_out (s1_v),
      .ed    (s1_ed),
      .nz    (s1_nz)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         // Leave RUN on the accept that fills the window so in_ready drops
         // on the very next cycle.
         RUN:     if (accept && (smp_inc == WIN_C)) state_d = DRAIN;
         DRAIN:   if (~|vld_pipe) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         RUN: begin
            in_ready = (smp_count_q < WIN_C);
            busy     = 1'b1;
         end
         DRAIN:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // ---------------- counters and S2 accumulation ----------------
   always_comb begin
      smp_count_d = smp_count_q;
      err_count_d = err_count_q;
      ed_sum_d    = ed_sum_q;
      ed_max_d    = ed_max_q;
      if (clear) begin
         smp_count_d = '0;
         err_count_d = '0;
         ed_sum_d    = '0;
         ed_max_d    = '0;
      end else begin
         if (accept) smp_count_d = smp_inc;
         if (s1_v) begin
            ed_sum_d    = ed_sum_q + SUM_W'(s1_ed);
            err_count_d = err_count_q + CNT_W'(s1_nz);
            if (s1_ed > ed_max_q) ed_max_d = s1_ed;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_count_q <= '0;
         err_count_q <= '0;
         ed_sum_q    <= '0;
         ed_max_q    <= '0;
      end else begin
         smp_count_q <= smp_count_d;
         err_count_q <= err_count_d;
         ed_sum_q    <= ed_sum_d;
         ed_max_q    <= ed_max_d;
      end
   end

   assign ed_sum    = ed_sum_q;
   assign ed_max    = ed_max_q;
   assign err_count = err_count_q;
   assign smp_count = smp_count_q;

endmodule
